crypto_wallet2_nios_entropy_collector: RTL

// Sequences the Raspberry-Pi random-word input for the Nios: synchronises the Pi's toggle strobe,

---
 rtl/crypto_wallet2_nios_entropy_collector.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/crypto_wallet2_nios_entropy_collector.sv
// Entropy collector: syncs the Pi toggle strobe, fills a seed buffer, runs a repetition health test.
// Avalon-MM slave, 1-cycle registered read latency, level irq on FULL/ERROR when enabled.
// No backpressure: strobes arriving outside COLLECT (or colliding with a control pulse) are dropped.
module crypto_wallet2_nios_entropy_collector #(
  parameter int NWORDS    = 8,
  parameter int REP_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  input  logic [31:0] rnd_data,
  input  logic        rnd_toggle
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2,
    ST_ERROR   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        s1_q, s2_q, s3_q;
  logic [3:0]  count_q, count_d;
  logic [3:0]  rep_q, rep_d;
  logic [31:0] buf_q [NWORDS];
  logic [31:0] buf_d [NWORDS];
  logic [15:0] drops_q, drops_d;
  logic        irq_en_q, irq_en_d;
  logic [31:0] readdata_q, readdata_d;

  logic        evt;
  logic        ctrl_wr;
  logic [31:0] prev_word;
  logic [3:0]  rep_next;
  logic [31:0] rd_val;
  logic        unused_wdata;

  // Upper write-data bits carry no control function.
  assign unused_wdata = ^writedata[31:4];

  // A level change that has crossed two flops is treated as one new-word event.
  assign evt     = s2_q ^ s3_q;
  assign ctrl_wr = write && (address == 4'h0);

  // Last captured word, used by the repetition test (only meaningful when count > 0).
  always_comb begin
    prev_word = 32'h0;
    for (int i = 0; i < NWORDS; i++) begin
      if (count_q == 4'(i + 1)) prev_word = buf_q[i];
    end
    if (count_q == 4'd0 || rnd_data != prev_word) rep_next = 4'd1;
    else                                          rep_next = rep_q + 4'd1;
  end

  // Control decode and capture sequencing; control pulses swallow any coincident event.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rep_d    = rep_q;
    drops_d  = drops_q;
    irq_en_d = irq_en_q;
    for (int i = 0; i < NWORDS; i++) buf_d[i] = buf_q[i];

    if (ctrl_wr) irq_en_d = writedata[1];

    if (ctrl_wr && writedata[3]) begin
      for (int i = 0; i < NWORDS; i++) buf_d[i] = 32'h0;
      count_d = 4'd0;
      rep_d   = 4'd0;
      state_d = ST_IDLE;
    end else if (ctrl_wr && writedata[2]) begin
      if (state_q == ST_ERROR) begin
        state_d = ST_IDLE;
        rep_d   = 4'd0;
      end
    end else if (ctrl_wr && writedata[0]) begin
      if (state_q != ST_ERROR) begin
        for (int i = 0; i < NWORDS; i++) buf_d[i] = 32'h0;
        count_d = 4'd0;
        rep_d   = 4'd0;
        state_d = ST_COLLECT;
      end
    end else if (evt) begin
      if (state_q == ST_COLLECT) begin
        rep_d = rep_next;
        if (rep_next == 4'(REP_LIMIT)) begin
          // A stuck source must never leave usable seed material behind.
          for (int i = 0; i < NWORDS; i++) buf_d[i] = 32'h0;
          count_d = 4'd0;
          state_d = ST_ERROR;
        end else begin
          for (int i = 0; i < NWORDS; i++) begin
            if (count_q == 4'(i)) buf_d[i] = rnd_data;
          end
          count_d = count_q + 4'd1;
          if (count_q + 4'd1 == 4'(NWORDS)) state_d = ST_FULL;
        end
      end else if (drops_q != 16'hFFFF) begin
        drops_d = drops_q + 16'd1;
      end
    end
  end

  // Register read mux; seed words are visible only once the seed is complete.
  always_comb begin
    rd_val = 32'h0;
    case (address)
      4'h0: rd_val = {31'h0, irq_en_q};
      4'h1: rd_val = {12'h0, rep_q, 4'h0, count_q, 6'h0, state_q};
      4'h2: rd_val = {16'h0, drops_q};
      default: begin
        if (address[3] && state_q == ST_FULL) begin
          for (int i = 0; i < NWORDS; i++) begin
            if (address[2:0] == 3'(i)) rd_val = buf_q[i];
          end
        end
      end
    endcase
    readdata_d = read ? rd_val : readdata_q;
  end

  // State, buffer and strobe-synchroniser registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      state_q    <= ST_IDLE;
      count_q    <= 4'd0;
      rep_q      <= 4'd0;
      drops_q    <= 16'd0;
      irq_en_q   <= 1'b0;
      readdata_q <= 32'h0;
      for (int i = 0; i < NWORDS; i++) buf_q[i] <= 32'h0;
    end else begin
      s1_q       <= rnd_toggle;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      state_q    <= state_d;
      count_q    <= count_d;
      rep_q      <= rep_d;
      drops_q    <= drops_d;
      irq_en_q   <= irq_en_d;
      readdata_q <= readdata_d;
      for (int i = 0; i < NWORDS; i++) buf_q[i] <= buf_d[i];
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_en_q & ((state_q == ST_FULL) | (state_q == ST_ERROR));

endmodule
